conway_frame_buffer: RTL and testbench

Double-buffered 640x480, 1-bit-per-cell generation store for the Conway pipeline. It answers the cell-update engine's read port from the front (current-generation) buffer and captures its writes into the back (next-generation) buffer. It swaps buffers on a display vertical-blank boundary and paces generations by issuing the engine's start pulse. It also serves the VGA scan-out read port from the front buffer and provides host seed/clear access.

---
 rtl/conway_frame_buffer.sv | 211 +++++++++++++++++++++
 tb/tb_conway_frame_buffer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conway_frame_buffer.sv
// Double-buffered 1-bit generation store for the Conway pipeline: engine/display reads
// from the front buffer, engine writes to the back buffer, swaps on vertical blank.
module conway_frame_buffer #(
    parameter int unsigned X_MAX      = 639,
    parameter int unsigned Y_MAX      = 479,
    parameter int unsigned GEN_PERIOD = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       clear,
    input  logic       seed_we,
    input  logic [9:0] seed_x,
    input  logic [8:0] seed_y,
    input  logic       seed_data,
    output logic       lg_start,
    input  logic [9:0] lg_rd_addr_x,
    input  logic [8:0] lg_rd_addr_y,
    output logic       lg_rd_data,
    input  logic       lg_wr_en,
    input  logic       lg_wr_data,
    input  logic [9:0] lg_wr_addr_x,
    input  logic [8:0] lg_wr_addr_y,
    input  logic [9:0] disp_rd_addr_x,
    input  logic [8:0] disp_rd_addr_y,
    output logic       disp_rd_data,
    input  logic       vblank_start,
    output logic       front_sel,
    output logic       busy,
    output logic [15:0] gen_count
);

    localparam int unsigned LW        = 19;
    localparam int unsigned DEPTH     = Y_MAX * 640 + X_MAX + 1;
    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [LW-1:0] LAST_ADDR = LW'(DEPTH - 1);
    localparam logic [7:0]  VB_LAST   = 8'(GEN_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_GEN,
        S_WAIT_SWAP,
        S_SWAP,
        S_HOLD
    } state_t;

    // Linear address y*640 + x built from shifts.
    function automatic logic [LW-1:0] f_lin(input logic [9:0] x, input logic [8:0] y);
        return (LW'(y) << 9) + (LW'(y) << 7) + LW'(x);
    endfunction

    function automatic logic f_in_range(input logic [9:0] x, input logic [8:0] y);
        return (32'(x) <= X_MAX) && (32'(y) <= Y_MAX);
    endfunction

    state_t          r_state;
    state_t          w_next;
    logic            r_front_sel;
    logic [15:0]     r_gen_count;
    logic [LW-1:0]   r_clr_addr;
    logic [7:0]      r_vb_cnt;
    logic            r_lg_start;
    logic            r_busy;
    logic            r_disp_rd_data;

    logic            r_mem_a [DEPTH];
    logic            r_mem_b [DEPTH];

    logic            w_lg_start_d;
    logic            w_busy_d;
    logic            w_seed_we;
    logic            w_clr_we;
    logic            w_eng_we;
    logic            w_swap;
    logic            w_vb_inc;
    logic            w_mem_we;
    logic            w_mem_to_back;
    logic [LW-1:0]   w_mem_addr;
    logic            w_mem_data;

    logic            w_wr_in;
    logic            w_wr_final;
    logic            w_seed_in;
    logic            w_lg_in;
    logic            w_disp_in;
    logic [LW-1:0]   w_wr_lin;
    logic [LW-1:0]   w_seed_lin;
    logic [LW-1:0]   w_lg_lin;
    logic [LW-1:0]   w_disp_lin;
    logic            w_lg_bit;
    logic            w_disp_bit;

    assign w_wr_lin   = f_lin(lg_wr_addr_x, lg_wr_addr_y);
    assign w_seed_lin = f_lin(seed_x, seed_y);
    assign w_lg_lin   = f_lin(lg_rd_addr_x, lg_rd_addr_y);
    assign w_disp_lin = f_lin(disp_rd_addr_x, disp_rd_addr_y);
    assign w_wr_in    = f_in_range(lg_wr_addr_x, lg_wr_addr_y);
    assign w_seed_in  = f_in_range(seed_x, seed_y);
    assign w_lg_in    = f_in_range(lg_rd_addr_x, lg_rd_addr_y);
    assign w_disp_in  = f_in_range(disp_rd_addr_x, disp_rd_addr_y);
    assign w_wr_final = lg_wr_en && (lg_wr_addr_x == 10'(X_MAX)) && (lg_wr_addr_y == 9'(Y_MAX));

    // Front-buffer read ports; out-of-range addresses read as 0.
    assign w_lg_bit   = r_front_sel ? r_mem_b[w_lg_lin[AW-1:0]]   : r_mem_a[w_lg_lin[AW-1:0]];
    assign w_disp_bit = r_front_sel ? r_mem_b[w_disp_lin[AW-1:0]] : r_mem_a[w_disp_lin[AW-1:0]];
    assign lg_rd_data = w_lg_in ? w_lg_bit : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (clear)    w_next = S_CLEAR;
                else if (run) w_next = S_GEN;
            end
            S_CLEAR:     if (r_clr_addr == LAST_ADDR) w_next = S_IDLE;
            S_GEN:       if (w_wr_final) w_next = S_WAIT_SWAP;
            S_WAIT_SWAP: if (vblank_start) w_next = S_SWAP;
            S_SWAP:      w_next = S_HOLD;
            S_HOLD: begin
                if (!run)                      w_next = S_IDLE;
                else if (r_vb_cnt == VB_LAST)  w_next = S_GEN;
            end
            default:     w_next = S_IDLE;
        endcase
    end

    // Per-state strobes and the single shared memory write port.
    always_comb begin
        w_seed_we     = 1'b0;
        w_clr_we      = 1'b0;
        w_eng_we      = 1'b0;
        w_swap        = 1'b0;
        w_vb_inc      = 1'b0;
        w_lg_start_d  = (w_next == S_GEN) && (r_state != S_GEN);
        w_busy_d      = (w_next != S_IDLE);
        case (r_state)
            S_IDLE:                w_seed_we = seed_we && !clear && w_seed_in;
            S_CLEAR:               w_clr_we  = 1'b1;
            S_GEN, S_WAIT_SWAP:    w_eng_we  = lg_wr_en && w_wr_in;
            S_SWAP:                w_swap    = 1'b1;
            S_HOLD:                w_vb_inc  = vblank_start;
            default:               w_seed_we = 1'b0;
        endcase
        w_mem_we      = w_seed_we || w_clr_we || w_eng_we;
        w_mem_to_back = w_eng_we;
        if (w_eng_we) begin
            w_mem_addr = w_wr_lin;
            w_mem_data = lg_wr_data;
        end else if (w_clr_we) begin
            w_mem_addr = r_clr_addr;
            w_mem_data = 1'b0;
        end else begin
            w_mem_addr = w_seed_lin;
            w_mem_data = seed_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_front_sel    <= 1'b0;
            r_gen_count    <= 16'd0;
            r_clr_addr     <= '0;
            r_vb_cnt       <= 8'd0;
            r_lg_start     <= 1'b0;
            r_busy         <= 1'b0;
            r_disp_rd_data <= 1'b0;
        end else begin
            r_lg_start     <= w_lg_start_d;
            r_busy         <= w_busy_d;
            r_disp_rd_data <= w_disp_in ? w_disp_bit : 1'b0;
            if (w_swap) begin
                r_front_sel <= ~r_front_sel;
                r_gen_count <= r_gen_count + 16'd1;
            end
            if (w_clr_we) begin
                r_clr_addr <= (r_clr_addr == LAST_ADDR) ? '0 : r_clr_addr + LW'(1);
            end
            if (w_swap) begin
                r_vb_cnt <= 8'd0;
            end else if (w_vb_inc) begin
                r_vb_cnt <= r_vb_cnt + 8'd1;
            end
        end
    end

    // Storage is not reset; back buffer is A whenever front_sel selects B and vice versa.
    always_ff @(posedge clk) begin
        if (w_mem_we && (w_mem_to_back == r_front_sel)) begin
            r_mem_a[w_mem_addr[AW-1:0]] <= w_mem_data;
        end
        if (w_mem_we && (w_mem_to_back != r_front_sel)) begin
            r_mem_b[w_mem_addr[AW-1:0]] <= w_mem_data;
        end
    end

    assign lg_start     = r_lg_start;
    assign busy         = r_busy;
    assign front_sel    = r_front_sel;
    assign gen_count    = r_gen_count;
    assign disp_rd_data = r_disp_rd_data;

endmodule

// File: tb/tb_conway_frame_buffer.sv
// Directed bench for conway_frame_buffer: two instances (GEN_PERIOD 1 and 3) on a
// reduced-height frame so a full clear sweep stays short.
module tb_conway_frame_buffer;

    localparam int unsigned XM    = 639;
    localparam int unsigned YM    = 59;
    localparam int unsigned DEPTH = YM * 640 + XM + 1;

    logic        clk = 1'b0;
    logic        rst, run, clear, seed_we, seed_data;
    logic [9:0]  seed_x, lg_rd_addr_x, lg_wr_addr_x, disp_rd_addr_x;
    logic [8:0]  seed_y, lg_rd_addr_y, lg_wr_addr_y, disp_rd_addr_y;
    logic        lg_wr_en, lg_wr_data, vblank_start;

    logic        lg_start, lg_rd_data, disp_rd_data, front_sel, busy;
    logic [15:0] gen_count;
    logic        lg_start3, lg_rd_data3, disp_rd_data3, front_sel3, busy3;
    logic [15:0] gen_count3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    conway_frame_buffer #(.X_MAX(XM), .Y_MAX(YM), .GEN_PERIOD(1)) u_dut (
        .clk(clk), .rst(rst), .run(run), .clear(clear),
        .seed_we(seed_we), .seed_x(seed_x), .seed_y(seed_y), .seed_data(seed_data),
        .lg_start(lg_start), .lg_rd_addr_x(lg_rd_addr_x), .lg_rd_addr_y(lg_rd_addr_y),
        .lg_rd_data(lg_rd_data), .lg_wr_en(lg_wr_en), .lg_wr_data(lg_wr_data),
        .lg_wr_addr_x(lg_wr_addr_x), .lg_wr_addr_y(lg_wr_addr_y),
        .disp_rd_addr_x(disp_rd_addr_x), .disp_rd_addr_y(disp_rd_addr_y),
        .disp_rd_data(disp_rd_data), .vblank_start(vblank_start),
        .front_sel(front_sel), .busy(busy), .gen_count(gen_count)
    );

    conway_frame_buffer #(.X_MAX(XM), .Y_MAX(YM), .GEN_PERIOD(3)) u_dut3 (
        .clk(clk), .rst(rst), .run(run), .clear(clear),
        .seed_we(seed_we), .seed_x(seed_x), .seed_y(seed_y), .seed_data(seed_data),
        .lg_start(lg_start3), .lg_rd_addr_x(lg_rd_addr_x), .lg_rd_addr_y(lg_rd_addr_y),
        .lg_rd_data(lg_rd_data3), .lg_wr_en(lg_wr_en), .lg_wr_data(lg_wr_data),
        .lg_wr_addr_x(lg_wr_addr_x), .lg_wr_addr_y(lg_wr_addr_y),
        .disp_rd_addr_x(disp_rd_addr_x), .disp_rd_addr_y(disp_rd_addr_y),
        .disp_rd_data(disp_rd_data3), .vblank_start(vblank_start),
        .front_sel(front_sel3), .busy(busy3), .gen_count(gen_count3)
    );

    typedef struct {
        int         phase;
        logic [9:0] x;
        logic [8:0] y;
        logic       exp;
    } rd_vec_t;

    rd_vec_t vecs[32];
    int      n_vecs = 0;

    function automatic void add_vec(input int ph, input int x, input int y, input logic e);
        vecs[n_vecs] = '{ph, 10'(x), 9'(y), e};
        n_vecs++;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic seed(input int x, input int y, input logic d);
        seed_we = 1'b1; seed_x = 10'(x); seed_y = 9'(y); seed_data = d;
        tick();
        seed_we = 1'b0;
    endtask

    task automatic eng_wr(input int x, input int y, input logic d);
        lg_wr_en = 1'b1; lg_wr_addr_x = 10'(x); lg_wr_addr_y = 9'(y); lg_wr_data = d;
        tick();
        lg_wr_en = 1'b0;
    endtask

    task automatic vblank();
        vblank_start = 1'b1;
        tick();
        vblank_start = 1'b0;
    endtask

    // Apply every read vector of one phase to both read ports.
    task automatic run_phase(input int ph);
        for (int i = 0; i < n_vecs; i++) begin
            if (vecs[i].phase == ph) begin
                lg_rd_addr_x   = vecs[i].x; lg_rd_addr_y   = vecs[i].y;
                disp_rd_addr_x = vecs[i].x; disp_rd_addr_y = vecs[i].y;
                #1;
                chk($sformatf("p%0d lg_rd(%0d,%0d)", ph, vecs[i].x, vecs[i].y), 32'(lg_rd_data), 32'(vecs[i].exp));
                chk($sformatf("p%0d lg_rd3(%0d,%0d)", ph, vecs[i].x, vecs[i].y), 32'(lg_rd_data3), 32'(vecs[i].exp));
                tick();
                chk($sformatf("p%0d disp_rd(%0d,%0d)", ph, vecs[i].x, vecs[i].y), 32'(disp_rd_data), 32'(vecs[i].exp));
            end
        end
    endtask

    initial begin
        int cnt;

        add_vec(1, 6, 5, 1'b1); add_vec(1, 6, 4, 1'b0); add_vec(1, 7, 5, 1'b1);
        add_vec(1, 5, 5, 1'b1); add_vec(1, 8, 5, 1'b0);
        add_vec(2, 6, 4, 1'b0); add_vec(2, 5, 5, 1'b1); add_vec(2, 6, 6, 1'b0);
        add_vec(3, 6, 4, 1'b1); add_vec(3, 5, 5, 1'b0); add_vec(3, 6, 5, 1'b1);
        add_vec(3, 6, 6, 1'b1); add_vec(3, 7, 5, 1'b0);
        add_vec(4, 6, 5, 1'b1);
        add_vec(5, 5, 5, 1'b1); add_vec(5, 6, 4, 1'b0); add_vec(5, 7, 5, 1'b1);
        add_vec(5, 6, 6, 1'b0); add_vec(5, XM, YM, 1'b1); add_vec(5, 6, 5, 1'b1);
        add_vec(6, 0, 0, 1'b0); add_vec(6, XM, YM, 1'b0); add_vec(6, 320, 30, 1'b0);
        add_vec(6, 5, 5, 1'b0); add_vec(6, 100, 10, 1'b0);
        add_vec(7, 700, 10, 1'b0); add_vec(7, 60, 11, 1'b1); add_vec(7, 10, 60, 1'b0);

        rst = 1'b1; run = 1'b0; clear = 1'b0; seed_we = 1'b0; seed_data = 1'b0;
        seed_x = '0; seed_y = '0; lg_rd_addr_x = '0; lg_rd_addr_y = '0;
        lg_wr_en = 1'b0; lg_wr_data = 1'b0; lg_wr_addr_x = '0; lg_wr_addr_y = '0;
        disp_rd_addr_x = '0; disp_rd_addr_y = '0; vblank_start = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        chk("rst lg_start", 32'(lg_start), 0);
        chk("rst front_sel", 32'(front_sel), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst gen_count", 32'(gen_count), 0);
        chk("rst disp_rd_data", 32'(disp_rd_data), 0);

        // Seed a horizontal blinker.
        seed(5, 5, 1'b1); seed(6, 5, 1'b1); seed(7, 5, 1'b1);
        run_phase(1);

        // Generation 1: engine writes the vertical blinker into back buffer B.
        run = 1'b1;
        tick();
        chk("gen1 lg_start rise", 32'(lg_start), 1);
        chk("gen1 lg_start3 rise", 32'(lg_start3), 1);
        chk("gen1 busy", 32'(busy), 1);
        tick();
        chk("gen1 lg_start single", 32'(lg_start), 0);
        eng_wr(6, 4, 1'b1); eng_wr(6, 6, 1'b1); eng_wr(5, 5, 1'b0);
        eng_wr(7, 5, 1'b0); eng_wr(6, 5, 1'b1);
        run_phase(2);
        // Final write coincides with vblank: no swap from that pulse.
        vblank_start = 1'b1;
        eng_wr(XM, YM, 1'b1);
        vblank_start = 1'b0;
        repeat (3) tick();
        chk("same-cycle vblank front_sel", 32'(front_sel), 0);
        chk("same-cycle vblank gen_count", 32'(gen_count), 0);
        chk("wait_swap busy", 32'(busy), 1);
        vblank();
        chk("swap cycle front_sel", 32'(front_sel), 0);
        tick();
        chk("post-swap front_sel", 32'(front_sel), 1);
        chk("post-swap gen_count", 32'(gen_count), 1);
        chk("post-swap gen_count3", 32'(gen_count3), 1);
        chk("hold lg_start", 32'(lg_start), 0);
        tick();
        chk("swap+2 lg_start", 32'(lg_start), 1);
        chk("swap+2 lg_start3", 32'(lg_start3), 0);
        run_phase(3);

        // GEN_PERIOD=3 instance needs two vblanks in HOLD.
        vblank();
        repeat (3) tick();
        chk("p3 after 1 vblank lg_start3", 32'(lg_start3), 0);
        chk("p3 hold busy3", 32'(busy3), 1);
        vblank();
        chk("p3 after 2 vblank lg_start3", 32'(lg_start3), 0);
        tick();
        chk("p3 lg_start3 rise", 32'(lg_start3), 1);
        tick();
        chk("p3 lg_start3 single", 32'(lg_start3), 0);
        chk("gen2 gen_count no early swap", 32'(gen_count), 1);

        // Generation 2: clear/seed during GEN are ignored.
        clear = 1'b1; seed_we = 1'b1; seed_x = 10'd6; seed_y = 9'd5; seed_data = 1'b0;
        tick();
        clear = 1'b0; seed_we = 1'b0;
        run_phase(4);
        eng_wr(5, 5, 1'b1); eng_wr(7, 5, 1'b1); eng_wr(6, 4, 1'b0);
        eng_wr(6, 6, 1'b0); eng_wr(6, 5, 1'b1); eng_wr(XM, YM, 1'b1);
        run = 1'b0;
        tick();
        chk("run drop still busy", 32'(busy), 1);
        vblank();
        tick();
        chk("gen2 front_sel", 32'(front_sel), 0);
        chk("gen2 gen_count", 32'(gen_count), 2);
        chk("gen2 gen_count3", 32'(gen_count3), 2);
        chk("gen2 hold busy", 32'(busy), 1);
        tick();
        chk("hold run=0 busy", 32'(busy), 0);
        chk("hold run=0 busy3", 32'(busy3), 0);
        run_phase(5);

        // Clear sweep; clear wins over a same-cycle seed write.
        seed(0, 0, 1'b1); seed(320, 30, 1'b1);
        clear = 1'b1; seed_we = 1'b1; seed_x = 10'd100; seed_y = 9'd10; seed_data = 1'b1;
        tick();
        clear = 1'b0; seed_we = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 50000) begin
            cnt++;
            tick();
        end
        chk("clear busy cycles", 32'(cnt), 32'(DEPTH));
        chk("clear done busy3", 32'(busy3), 0);
        run_phase(6);

        // Out-of-range: (700,10) aliases linear address of (60,11).
        seed(60, 11, 1'b1);
        seed(700, 10, 1'b0);
        seed(10, 60, 1'b1);
        run_phase(7);

        // Reset in the middle of a generation after a swap.
        run = 1'b1;
        tick();
        eng_wr(XM, YM, 1'b1);
        vblank();
        tick();
        chk("gen3 front_sel", 32'(front_sel), 1);
        chk("gen3 gen_count", 32'(gen_count), 3);
        tick();
        chk("gen4 lg_start", 32'(lg_start), 1);
        rst = 1'b1; run = 1'b0;
        tick();
        rst = 1'b0;
        chk("midrst lg_start", 32'(lg_start), 0);
        chk("midrst front_sel", 32'(front_sel), 0);
        chk("midrst gen_count", 32'(gen_count), 0);
        chk("midrst busy", 32'(busy), 0);
        chk("midrst front_sel3", 32'(front_sel3), 0);
        chk("midrst gen_count3", 32'(gen_count3), 0);
        tick();
        chk("midrst idle busy", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
